ok_arith_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed wire-in/wire-out adder path.
- Takes NUM_CH operand pairs from host WireIn buses and computes per-channel results with one shared arithmetic unit, stepped by an FSM.
- Publishes results atomically, with busy/done/overflow status, for host WireOut readback.
- Also debounces raw board buttons into level and sticky-press status bits.
- Sits between the host-interface endpoints and the host-visible status/result wires, in the ti_clk domain.

---
 rtl/ok_arith_pkg.sv | 19 +
 rtl/ok_arith_bank_btn_debounce.sv | 51 +++++
 rtl/ok_arith_bank.sv | 215 +++++++++++++++++++++
 tb/tb_ok_arith_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ok_arith_pkg.sv
// Shared mode encodings, FSM state type and default sizes for ok_arith_bank.
package ok_arith_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_DATA_W = 16;

    localparam logic [1:0] MODE_ADD    = 2'b00;
    localparam logic [1:0] MODE_SUB    = 2'b01;
    localparam logic [1:0] MODE_SATADD = 2'b10;
    localparam logic [1:0] MODE_PASSA  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SNAP = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/ok_arith_bank_btn_debounce.sv
// One-button debouncer: 2-flop synchroniser on the active-low raw input,
// stability counter, and an active-high debounced level with a rise strobe.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic ti_clk,
    input  logic rst,
    input  logic button_n,
    output logic state,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             pressed;

    // Synchroniser idles at the released (high) level so reset never looks like a press.
    always_comb begin
        sync_d  = {sync_q[0], button_n};
        pressed = ~sync_q[1];
        cnt_d   = '0;
        state_d = state_q;
        if (pressed != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign rise  = state_d & ~state_q;

endmodule

// File: rtl/ok_arith_bank.sv
// Multi-channel arithmetic bank with atomic result publish and button debouncing.
// Define OK_ARITH_CHECKSUM_EN to build the XOR checksum on csum; otherwise csum is 0.
module ok_arith_bank
    import ok_arith_pkg::*;
#(
    parameter int NUM_CH       = DEFAULT_NUM_CH,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int BTN_W        = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                     ti_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [NUM_CH*DATA_W-1:0] op_a,
    input  logic [NUM_CH*DATA_W-1:0] op_b,
    output logic [NUM_CH*DATA_W-1:0] result,
    output logic [NUM_CH-1:0]        ovf,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        csum,
    input  logic [BTN_W-1:0]         button,
    output logic [BTN_W-1:0]         btn_state,
    output logic [BTN_W-1:0]         btn_press,
    input  logic                     btn_clr
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_t                    state_q, state_d;
    logic                      start_prev_q, start_prev_d;
    logic [1:0]                mode_sh_q, mode_sh_d;
    logic [NUM_CH*DATA_W-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_CH*DATA_W-1:0]  stage_res_q, stage_res_d;
    logic [NUM_CH-1:0]         stage_ovf_q, stage_ovf_d;
    logic [NUM_CH*DATA_W-1:0]  result_q, result_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [BTN_W-1:0]          btn_press_q, btn_press_d, btn_rise;

    logic                      start_edge, last_ch, publish;
    logic [DATA_W-1:0]         a_ch, b_ch, ch_res;
    logic [DATA_W:0]           sum_w, diff_w;
    logic                      ch_ovf;

    assign start_edge = start & ~start_prev_q;
    assign last_ch    = (idx_q == LAST_IDX);
    assign publish    = (state_q == CALC) && last_ch;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = SNAP;
            SNAP:    state_d = CALC;
            CALC:    if (last_ch) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared unit: DATA_W+1 bit sum/difference, top bit is carry or borrow.
    always_comb begin
        a_ch   = a_sh_q[int'(idx_q)*DATA_W +: DATA_W];
        b_ch   = b_sh_q[int'(idx_q)*DATA_W +: DATA_W];
        sum_w  = {1'b0, a_ch} + {1'b0, b_ch};
        diff_w = {1'b0, a_ch} - {1'b0, b_ch};
        ch_res = a_ch;
        ch_ovf = 1'b0;
        case (mode_sh_q)
            MODE_ADD: begin
                ch_res = sum_w[DATA_W-1:0];
                ch_ovf = sum_w[DATA_W];
            end
            MODE_SUB: begin
                ch_res = diff_w[DATA_W-1:0];
                ch_ovf = diff_w[DATA_W];
            end
            MODE_SATADD: begin
                ch_res = sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
                ch_ovf = sum_w[DATA_W];
            end
            default: begin
                ch_res = a_ch;
                ch_ovf = 1'b0;
            end
        endcase
    end

    // Results go public on the edge that writes the last channel, so the
    // final channel is forwarded from the staging next-value.
    always_comb begin
        start_prev_d = start;
        mode_sh_d    = mode_sh_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        idx_d        = idx_q;
        stage_res_d  = stage_res_q;
        stage_ovf_d  = stage_ovf_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        busy_d       = busy_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            SNAP: begin
                mode_sh_d = mode;
                a_sh_d    = op_a;
                b_sh_d    = op_b;
                idx_d     = '0;
            end
            CALC: begin
                stage_res_d[int'(idx_q)*DATA_W +: DATA_W] = ch_res;
                stage_ovf_d[idx_q] = ch_ovf;
                idx_d = idx_q + 1'b1;
                if (last_ch) begin
                    result_d = stage_res_d;
                    ovf_d    = stage_ovf_d;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            mode_sh_q    <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            idx_q        <= '0;
            stage_res_q  <= '0;
            stage_ovf_q  <= '0;
            result_q     <= '0;
            ovf_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            btn_press_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            mode_sh_q    <= mode_sh_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            idx_q        <= idx_d;
            stage_res_q  <= stage_res_d;
            stage_ovf_q  <= stage_ovf_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            btn_press_q  <= btn_press_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef OK_ARITH_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (publish) begin
            csum_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                csum_d = csum_d ^ stage_res_d[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_btn (
            .ti_clk   (ti_clk),
            .rst      (rst),
            .button_n (button[g]),
            .state    (btn_state[g]),
            .rise     (btn_rise[g])
        );
    end

    // A new press outranks a simultaneous clear.
    always_comb begin
        btn_press_d = (btn_press_q & ~{BTN_W{btn_clr}}) | btn_rise;
    end

    assign btn_press = btn_press_q;

endmodule

// File: tb/tb_ok_arith_bank.sv
// Directed, table-driven bench for ok_arith_bank (NUM_CH=4, DATA_W=16, BTN_W=4).
module tb_ok_arith_bank;
    import ok_arith_pkg::*;

    logic        ti_clk = 1'b0;
    logic        rst, start, btn_clr;
    logic [1:0]  mode;
    logic [63:0] op_a, op_b, result;
    logic [3:0]  ovf, button, btn_state, btn_press;
    logic        busy, done;
    logic [15:0] csum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  ovf;
    } vec_t;

    vec_t vecs[6];

    always #5 ti_clk = ~ti_clk;

    ok_arith_bank #(
        .NUM_CH(4), .DATA_W(16), .BTN_W(4), .DEBOUNCE_CYC(16)
    ) dut (
        .ti_clk    (ti_clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .result    (result),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done),
        .csum      (csum),
        .button    (button),
        .btn_state (btn_state),
        .btn_press (btn_press),
        .btn_clr   (btn_clr)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expCsum(input logic [63:0] r);
        logic [15:0] x;
        x = '0;
`ifdef OK_ARITH_CHECKSUM_EN
        for (int i = 0; i < 4; i++) x = x ^ r[i*16 +: 16];
`endif
        return x;
    endfunction

    // Sets up operands with start low, then raises start on the next negedge (cycle t).
    task automatic applyStimulus(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        start = 1'b0;
        mode  = m;
        op_a  = a;
        op_b  = b;
        @(negedge ti_clk);
        start = 1'b1;
    endtask

    task automatic expectRun(input vec_t v, input string tag);
        for (int k = 1; k <= 5; k++) begin
            @(negedge ti_clk);
            checkOutput({tag, " busy"}, 64'(busy), 64'd1);
            if (k == 1) checkOutput({tag, " done cleared"}, 64'(done), 64'd0);
        end
        @(negedge ti_clk);
        checkOutput({tag, " busy end"}, 64'(busy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " result"}, result, v.res);
        checkOutput({tag, " ovf"}, 64'(ovf), 64'(v.ovf));
        checkOutput({tag, " csum"}, 64'(csum), 64'(expCsum(v.res)));
    endtask

    initial begin
        vecs[0] = '{MODE_ADD,    64'h8000_0100_FFFF_0001, 64'h8000_0200_0001_0002,
                    64'h0000_0300_0000_0003, 4'b1010};
        vecs[1] = '{MODE_SATADD, 64'h8000_0100_FFFF_0001, 64'h8000_0200_0001_0002,
                    64'hFFFF_0300_FFFF_0003, 4'b1010};
        vecs[2] = '{MODE_PASSA,  64'h8000_0100_FFFF_0001, 64'h8000_0200_0001_0002,
                    64'h8000_0100_FFFF_0001, 4'b0000};
        vecs[3] = '{MODE_SUB,    64'h1234_0000_0007_0005, 64'h0234_0000_0005_0007,
                    64'h1000_0000_0002_FFFE, 4'b0001};
        vecs[4] = '{MODE_ADD,    64'h7FFF_FFFF_0000_1234, 64'h0001_FFFF_0000_4321,
                    64'h8000_FFFE_0000_5555, 4'b0100};
        vecs[5] = '{MODE_SATADD, 64'h7FFF_FFFF_0000_1234, 64'h0001_FFFF_0000_4321,
                    64'h8000_FFFF_0000_5555, 4'b0100};

        rst = 1'b1; start = 1'b0; mode = '0; op_a = '0; op_b = '0;
        button = 4'hF; btn_clr = 1'b0;
        repeat (3) @(negedge ti_clk);
        rst = 1'b0;
        @(negedge ti_clk);
        checkOutput("reset result", result, 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset csum", 64'(csum), 64'd0);
        checkOutput("reset btn_state", 64'(btn_state), 64'd0);
        checkOutput("reset btn_press", 64'(btn_press), 64'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b);
            expectRun(vecs[i], $sformatf("vec%0d", i));
            start = 1'b0;
            repeat (2) @(negedge ti_clk);
        end

        // Second start edge while busy and operand change after SNAP are both ignored.
        applyStimulus(vecs[0].mode, vecs[0].a, vecs[0].b);
        repeat (2) @(negedge ti_clk);
        op_a  = 64'h1111_2222_3333_4444;
        mode  = MODE_PASSA;
        start = 1'b0;
        @(negedge ti_clk);
        start = 1'b1;
        repeat (2) @(negedge ti_clk);
        checkOutput("ignore busy", 64'(busy), 64'd1);
        @(negedge ti_clk);
        checkOutput("ignore done", 64'(done), 64'd1);
        checkOutput("ignore result", result, vecs[0].res);
        checkOutput("ignore ovf", 64'(ovf), 64'(vecs[0].ovf));
        repeat (4) @(negedge ti_clk);
        checkOutput("no queued run busy", 64'(busy), 64'd0);
        checkOutput("no queued run done", 64'(done), 64'd1);
        start = 1'b0;
        repeat (2) @(negedge ti_clk);

        // Reset mid-CALC with start held high through and after reset.
        applyStimulus(vecs[1].mode, vecs[1].a, vecs[1].b);
        repeat (3) @(negedge ti_clk);
        rst = 1'b1;
        repeat (2) @(negedge ti_clk);
        rst = 1'b0;
        @(negedge ti_clk);
        checkOutput("abort result", result, 64'd0);
        checkOutput("abort ovf", 64'(ovf), 64'd0);
        checkOutput("abort csum", 64'(csum), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        repeat (10) @(negedge ti_clk);
        checkOutput("held start busy", 64'(busy), 64'd0);
        checkOutput("held start done", 64'(done), 64'd0);
        start = 1'b0;
        @(negedge ti_clk);
        start = 1'b1;
        expectRun(vecs[1], "post-reset run");
        start = 1'b0;
        repeat (2) @(negedge ti_clk);

        // Bouncing low pulses shorter than the debounce window.
        button[0] = 1'b0;
        repeat (15) @(negedge ti_clk);
        button[0] = 1'b1;
        repeat (3) @(negedge ti_clk);
        button[0] = 1'b0;
        repeat (10) @(negedge ti_clk);
        button[0] = 1'b1;
        repeat (4) @(negedge ti_clk);
        checkOutput("bounce btn_state", 64'(btn_state), 64'd0);
        checkOutput("bounce btn_press", 64'(btn_press), 64'd0);

        // Stable press: state flips exactly 18 cycles after the edge.
        button[0] = 1'b0;
        repeat (17) @(negedge ti_clk);
        checkOutput("press 17cyc state", 64'(btn_state), 64'd0);
        @(negedge ti_clk);
        checkOutput("press 18cyc state", 64'(btn_state), 64'h1);
        checkOutput("press 18cyc press", 64'(btn_press), 64'h1);
        btn_clr = 1'b1;
        @(negedge ti_clk);
        btn_clr = 1'b0;
        checkOutput("clr press", 64'(btn_press), 64'd0);
        checkOutput("clr keeps state", 64'(btn_state), 64'h1);
        button[0] = 1'b1;
        repeat (20) @(negedge ti_clk);
        checkOutput("release state", 64'(btn_state), 64'd0);
        checkOutput("release press", 64'(btn_press), 64'd0);

        // Clear coinciding with a new press: set wins.
        button[1] = 1'b0;
        repeat (17) @(negedge ti_clk);
        btn_clr = 1'b1;
        @(negedge ti_clk);
        btn_clr = 1'b0;
        checkOutput("set-wins state", 64'(btn_state), 64'h2);
        checkOutput("set-wins press", 64'(btn_press), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
